// File: rtl/gray_cnt_ctrl.sv
// Sequencer for the 4-bit Gray counter: prescaled clk_en generation,
// free-run / N-step / single-step control and Gray step checking.
module gray_cnt_ctrl #(
    parameter int PS_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [PS_W-1:0]  prescale,
    input  logic [CNT_W-1:0] count_n,
    input  logic [3:0]       gray_in,
    output logic             clk_en,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    function automatic logic [3:0] succ(input logic [3:0] g);
        logic [3:0] s;
        s = 4'h0;
        unique case (g)
            4'h0: s = 4'h1;
            4'h1: s = 4'h3;
            4'h3: s = 4'h2;
            4'h2: s = 4'h6;
            4'h6: s = 4'h7;
            4'h7: s = 4'h5;
            4'h5: s = 4'h4;
            4'h4: s = 4'hC;
            4'hC: s = 4'hD;
            4'hD: s = 4'hF;
            4'hF: s = 4'hE;
            4'hE: s = 4'hA;
            4'hA: s = 4'hB;
            4'hB: s = 4'h9;
            4'h9: s = 4'h8;
            4'h8: s = 4'h0;
        endcase
        return s;
    endfunction

    state_t           state, state_d;
    logic [PS_W-1:0]  ps_r, ps_d;
    logic [CNT_W-1:0] n_r, n_d;
    logic [PS_W-1:0]  div_cnt, div_d;
    logic [CNT_W-1:0] step_cnt, step_d;
    logic [3:0]       exp_g, exp_d;
    logic             chk;
    logic             fin, fin_d;
    logic             clk_en_d, busy_d, wrap_d, err_d;
    logic             load_exp, clear_err;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        ps_d      = ps_r;
        n_d       = n_r;
        div_d     = div_cnt;
        step_d    = step_cnt;
        clk_en_d  = 1'b0;
        fin_d     = 1'b0;
        load_exp  = 1'b0;
        clear_err = 1'b0;

        unique case (state)
            IDLE: begin
                // stop outranks start, start outranks step
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    ps_d      = prescale;
                    n_d       = count_n;
                    div_d     = '0;
                    step_d    = '0;
                    clear_err = 1'b1;
                    load_exp  = 1'b1;
                    state_d   = RUN;
                end else if (step) begin
                    load_exp = 1'b1;
                    clk_en_d = 1'b1;
                    state_d  = STEP;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (div_cnt == ps_r) begin
                    div_d    = '0;
                    clk_en_d = 1'b1;
                    if (step_cnt != '1) begin
                        step_d = step_cnt + 1'b1;
                    end
                    // this pulse is the n_r-th: leave RUN on the same edge
                    if ((n_r != '0) && (step_cnt == n_r - 1'b1)) begin
                        state_d = IDLE;
                        fin_d   = 1'b1;
                    end
                end else begin
                    div_d = div_cnt + 1'b1;
                end
            end
            STEP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Checker: chk marks the cycle after a pulse, when gray_in has moved.
        exp_d  = exp_g;
        err_d  = err;
        wrap_d = 1'b0;
        if (clear_err) begin
            err_d = 1'b0;
        end
        if (chk) begin
            if (gray_in != exp_g) begin
                err_d = 1'b1;
                exp_d = succ(gray_in);
            end else begin
                exp_d = succ(exp_g);
            end
            wrap_d = (exp_g == 4'h0) && (gray_in == 4'h0);
        end
        if (load_exp) begin
            exp_d = succ(gray_in);
        end

        // The final pulse cycle still counts as busy so busy drops with done.
        busy_d = (state_d != IDLE) || clk_en_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ps_r     <= '0;
            n_r      <= '0;
            div_cnt  <= '0;
            step_cnt <= '0;
            exp_g    <= 4'h0;
            chk      <= 1'b0;
            fin      <= 1'b0;
            clk_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wrap     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_d;
            ps_r     <= ps_d;
            n_r      <= n_d;
            div_cnt  <= div_d;
            step_cnt <= step_d;
            exp_g    <= exp_d;
            chk      <= clk_en;
            fin      <= fin_d;
            clk_en   <= clk_en_d;
            busy     <= busy_d;
            done     <= fin;
            wrap     <= wrap_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_gray_cnt_ctrl.sv
// Directed bench for gray_cnt_ctrl with a behavioural Gray counter closing
// the clk_en -> gray_in loop; the counter can be preloaded to inject faults.
module tb_gray_cnt_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       step = 1'b0;
    logic [7:0] prescale = 8'd0;
    logic [7:0] count_n = 8'd0;
    logic [3:0] gray_in;
    logic       clk_en, busy, done, wrap, err;

    logic [3:0] cnt;
    logic       cnt_load = 1'b0;
    logic [3:0] cnt_val = 4'h0;

    int passed = 0;
    int total = 0;

    localparam logic [3:0] SEQ [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                        4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    localparam logic [3:0] RUN5_G [5] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6};

    gray_cnt_ctrl #(.PS_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
        .prescale(prescale), .count_n(count_n), .gray_in(gray_in),
        .clk_en(clk_en), .busy(busy), .done(done), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] nxt(input logic [3:0] g);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (SEQ[i] == g) r = SEQ[(i + 1) % 16];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst)          cnt <= 4'h0;
        else if (cnt_load) cnt <= cnt_val;
        else if (clk_en)   cnt <= nxt(cnt);
    end
    assign gray_in = cnt;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_cnt(input logic [3:0] v);
        cnt_load = 1'b1; cnt_val = v;
        cyc(1);
        cnt_load = 1'b0;
    endtask

    task automatic test_reset;
        cyc(2);
        total++;
        if ({clk_en, busy, done, wrap, err} !== 5'b0)
            $display("FAIL reset_held: got %b required 00000", {clk_en, busy, done, wrap, err});
        else passed++;
        rst = 1'b1;
        cyc(2);
        total++;
        if ({clk_en, busy, done, wrap, err} !== 5'b0 || gray_in !== 4'h0)
            $display("FAIL reset_idle: got %b gray %h required 00000 gray 0",
                     {clk_en, busy, done, wrap, err}, gray_in);
        else passed++;
    endtask

    task automatic test_run5;
        start = 1'b1; prescale = 8'd0; count_n = 8'd5;
        cyc(1);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || clk_en !== 1'b0)
            $display("FAIL run5_start: busy %b clk_en %b required 1 0", busy, clk_en);
        else passed++;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            total++;
            if (clk_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || gray_in !== RUN5_G[k])
                $display("FAIL run5_pulse%0d: clk_en %b busy %b done %b gray %h required 1 1 0 %h",
                         k, clk_en, busy, done, gray_in, RUN5_G[k]);
            else passed++;
        end
        cyc(1);
        total++;
        if (clk_en !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || gray_in !== 4'h7)
            $display("FAIL run5_done: clk_en %b done %b busy %b gray %h required 0 1 0 7",
                     clk_en, done, busy, gray_in);
        else passed++;
        cyc(1);
        total++;
        if (done !== 1'b0 || err !== 1'b0)
            $display("FAIL run5_after: done %b err %b required 0 0", done, err);
        else passed++;
    endtask

    task automatic test_prescale;
        logic ce_exp;
        start = 1'b1; prescale = 8'd3; count_n = 8'd4;
        cyc(1);
        start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            cyc(1);
            ce_exp = (k == 4) || (k == 8) || (k == 12) || (k == 16);
            total++;
            if (clk_en !== ce_exp || busy !== (k <= 16) || done !== (k == 17))
                $display("FAIL ps3_cycle%0d: clk_en %b busy %b done %b required %b %b %b",
                         k, clk_en, busy, done, ce_exp, (k <= 16), (k == 17));
            else passed++;
        end
        cyc(1);
        total++;
        if (err !== 1'b0 || gray_in !== 4'hD || done !== 1'b0)
            $display("FAIL ps3_end: err %b gray %h done %b required 0 D 0", err, gray_in, done);
        else passed++;
    endtask

    task automatic test_free_wrap;
        load_cnt(4'h0);
        start = 1'b1; prescale = 8'd0; count_n = 8'd0;
        cyc(1);
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            total++;
            if (wrap !== (k == 18) || clk_en !== 1'b1 || done !== 1'b0)
                $display("FAIL free_cycle%0d: wrap %b clk_en %b done %b required %b 1 0",
                         k, wrap, clk_en, done, (k == 18));
            else passed++;
        end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        total++;
        if (clk_en !== 1'b0 || busy !== 1'b0 || gray_in !== 4'h6)
            $display("FAIL free_stop: clk_en %b busy %b gray %h required 0 0 6", clk_en, busy, gray_in);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            total++;
            if (clk_en !== 1'b0 || done !== 1'b0 || wrap !== 1'b0 || err !== 1'b0 || gray_in !== 4'h6)
                $display("FAIL free_after%0d: clk_en %b done %b wrap %b err %b gray %h required 0 0 0 0 6",
                         k, clk_en, done, wrap, err, gray_in);
            else passed++;
        end
    endtask

    task automatic test_fault;
        load_cnt(4'h0);
        start = 1'b1; prescale = 8'd0; count_n = 8'd0;
        cyc(1);
        start = 1'b0;
        cyc(3);
        // counter shows 3 with a pulse pending: make it jump to 6 instead of 2
        cnt_load = 1'b1; cnt_val = 4'h6;
        cyc(1);
        cnt_load = 1'b0;
        total++;
        if (gray_in !== 4'h6 || err !== 1'b0)
            $display("FAIL fault_check_cycle: gray %h err %b required 6 0", gray_in, err);
        else passed++;
        cyc(1);
        total++;
        if (err !== 1'b1)
            $display("FAIL fault_err_rise: err %b required 1", err);
        else passed++;
        cyc(2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(1);
        total++;
        if (err !== 1'b1)
            $display("FAIL fault_err_sticky: err %b required 1", err);
        else passed++;
        start = 1'b1; prescale = 8'd0; count_n = 8'd1;
        cyc(1);
        start = 1'b0;
        total++;
        if (err !== 1'b0)
            $display("FAIL fault_err_clear: err %b required 0", err);
        else passed++;
        cyc(2);
        total++;
        if (done !== 1'b1 || err !== 1'b0)
            $display("FAIL fault_rerun: done %b err %b required 1 0", done, err);
        else passed++;
    endtask

    task automatic test_step;
        load_cnt(4'h4);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        total++;
        if (clk_en !== 1'b1 || busy !== 1'b1)
            $display("FAIL step_pulse: clk_en %b busy %b required 1 1", clk_en, busy);
        else passed++;
        cyc(1);
        total++;
        if (clk_en !== 1'b0 || busy !== 1'b0 || gray_in !== 4'hC)
            $display("FAIL step_after: clk_en %b busy %b gray %h required 0 0 C", clk_en, busy, gray_in);
        else passed++;
        cyc(1);
        total++;
        if (err !== 1'b0 || clk_en !== 1'b0 || gray_in !== 4'hC)
            $display("FAIL step_check: err %b clk_en %b gray %h required 0 0 C", err, clk_en, gray_in);
        else passed++;
        // step held during a run must not add pulses
        start = 1'b1; prescale = 8'd3; count_n = 8'd2;
        cyc(1);
        start = 1'b0;
        step = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc(1);
            if (k == 2) step = 1'b0;
            total++;
            if (clk_en !== ((k == 4) || (k == 8)) || done !== (k == 9))
                $display("FAIL step_in_run%0d: clk_en %b done %b required %b %b",
                         k, clk_en, done, ((k == 4) || (k == 8)), (k == 9));
            else passed++;
        end
        cyc(1);
        total++;
        if (gray_in !== 4'hF || err !== 1'b0)
            $display("FAIL step_run_end: gray %h err %b required F 0", gray_in, err);
        else passed++;
    endtask

    task automatic test_reset_midrun;
        load_cnt(4'h0);
        start = 1'b1; prescale = 8'd2; count_n = 8'd0;
        cyc(1);
        start = 1'b0;
        cyc(3);
        total++;
        if (clk_en !== 1'b1)
            $display("FAIL rstmid_first_pulse: clk_en %b required 1", clk_en);
        else passed++;
        cnt_load = 1'b1; cnt_val = 4'hA;
        cyc(1);
        cnt_load = 1'b0;
        cyc(2);
        total++;
        if (clk_en !== 1'b1 || err !== 1'b1 || busy !== 1'b1)
            $display("FAIL rstmid_before: clk_en %b err %b busy %b required 1 1 1", clk_en, err, busy);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if ({clk_en, busy, done, wrap, err} !== 5'b0)
            $display("FAIL rstmid_async: got %b required 00000", {clk_en, busy, done, wrap, err});
        else passed++;
        cyc(2);
        rst = 1'b1;
        cyc(3);
        total++;
        if ({clk_en, busy, done, wrap, err} !== 5'b0)
            $display("FAIL rstmid_idle: got %b required 00000", {clk_en, busy, done, wrap, err});
        else passed++;
        start = 1'b1; prescale = 8'd0; count_n = 8'd1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        total++;
        if (clk_en !== 1'b1)
            $display("FAIL rstmid_restart_pulse: clk_en %b required 1", clk_en);
        else passed++;
        cyc(1);
        total++;
        if (done !== 1'b1 || gray_in !== 4'h1 || clk_en !== 1'b0)
            $display("FAIL rstmid_restart_done: done %b gray %h clk_en %b required 1 1 0",
                     done, gray_in, clk_en);
        else passed++;
        cyc(1);
        total++;
        if (err !== 1'b0 || done !== 1'b0)
            $display("FAIL rstmid_restart_err: err %b done %b required 0 0", err, done);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_run5();
        test_prescale();
        test_free_wrap();
        test_fault();
        test_step();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
